// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide, one bit per cycle,
// with a one-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [2:0]        funct_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic              negq_q;
  logic              negr_q;
  logic [CW-1:0]     cnt_q;
  logic [XLEN-1:0]   res_q;

  // Operand decode at accept time
  logic            op1_signed, op2_signed, op1_neg, op2_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  always_comb begin
    op1_signed = funct_i[2] ? ~funct_i[0] : (funct_i[1:0] != 2'b11);
    op2_signed = funct_i[2] ? ~funct_i[0] : ~funct_i[1];
    op1_neg    = op1_signed & op1_i[XLEN-1];
    op2_neg    = op2_signed & op2_i[XLEN-1];
    a_mag      = op1_neg ? -op1_i : op1_i;
    b_mag      = op2_neg ? -op2_i : op2_i;
    is_div     = funct_i[2];
    div_zero   = is_div & (op2_i == '0);
    div_ovf    = is_div & ~funct_i[0] & (op1_i == INT_MIN) & (op2_i == '1);
    fast       = div_zero | div_ovf;
    if (div_zero) fast_res = funct_i[1] ? op1_i : '1;
    else          fast_res = funct_i[1] ? '0 : op1_i;
  end

  // One iteration step of either datapath, plus sign application for the final step
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_s;
  logic [XLEN-1:0]   quo, rem, res_fin;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    // Borrow out of the trial subtraction means the divisor did not fit: restore
    if (div_diff[XLEN]) div_next = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    else                div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    acc_step = funct_q[2] ? div_next : mul_next;
    prod_s   = negq_q ? -acc_step : acc_step;
    quo      = acc_step[XLEN-1:0];
    rem      = acc_step[2*XLEN-1:XLEN];
    unique case (funct_q)
      3'b000:                 res_fin = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_fin = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res_fin = negq_q ? -quo : quo;
      default:                res_fin = negr_q ? -rem : rem;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      funct_q <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i && !flush_i) begin
            funct_q <= funct_i;
            negq_q  <= op1_neg ^ op2_neg;
            negr_q  <= op1_neg;
            cnt_q   <= '0;
            if (fast) begin
              res_q   <= fast_res;
              state_q <= DONE;
            end else begin
              opnd_q  <= is_div ? b_mag : a_mag;
              acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_step;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN - 1)) begin
              res_q   <= res_fin;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (flush_i || ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign res_o   = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at XLEN=32, plus backpressure/flush/reset sequences.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, valid_i, ready_i;
  logic            ready_o, valid_o;
  logic [2:0]      funct_i;
  logic [XLEN-1:0] op1_i, op2_i, res_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .funct_i (funct_i),
    .op1_i   (op1_i),
    .op2_i   (op2_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .res_o   (res_o)
  );

  typedef struct {
    logic [2:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] e, input int l, input string n);
    vec_t v;
    v.funct = f; v.op1 = a; v.op2 = b; v.exp = e; v.lat = l; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input int exp_lat, input string name);
    int lat;
    int rdy_hi;
    chk({name, " ready_before"}, 32'(ready_o), 32'd1);
    funct_i = f; op1_i = a; op2_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    op1_i   = $urandom;
    op2_i   = $urandom;
    funct_i = 3'($urandom);
    lat = 1;
    rdy_hi = 0;
    while (!valid_o && lat < 100) begin
      if (ready_o) rdy_hi++;
      @(posedge clk_i); #1;
      lat++;
    end
    chk({name, " valid"}, 32'(valid_o), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " res"}, res_o, e);
    chk({name, " ready_while_busy"}, 32'(rdy_hi), 32'd0);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk({name, " ready_after"}, 32'(ready_o), 32'd1);
    chk({name, " valid_after"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int seen;
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    funct_i = '0; op1_i = '0; op2_i = '0;

    addv(3'b000, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul_7_m3");
    addv(3'b001, 32'h80000000,   32'h80000000, 32'h40000000, 33, "mulh_min_min");
    addv(3'b011, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu_max");
    addv(3'b010, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33, "mulhsu_m1_max");
    addv(3'b000, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000001, 33, "mul_m1_m1");
    addv(3'b001, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'h00000000, 33, "mulh_m1_m1");
    addv(3'b011, 32'h80000000,   32'd2,        32'h00000001, 33, "mulhu_carry");
    addv(3'b100, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33, "div_m7_2");
    addv(3'b110, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33, "rem_m7_2");
    addv(3'b101, 32'hFFFFFFF9,   32'd2,        32'h7FFFFFFC, 33, "divu_big_2");
    addv(3'b111, 32'hFFFFFFF9,   32'd2,        32'h00000001, 33, "remu_big_2");
    addv(3'b100, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 33, "div_m100_7");
    addv(3'b110, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFFE, 33, "rem_m100_7");
    addv(3'b100, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 33, "div_100_m7");
    addv(3'b110, 32'd100,        32'hFFFFFFF9, 32'h00000002, 33, "rem_100_m7");
    addv(3'b111, 32'd100,        32'd7,        32'h00000002, 33, "remu_100_7");
    addv(3'b100, 32'd5,          32'd0,        32'hFFFFFFFF, 1,  "div_by0");
    addv(3'b110, 32'd5,          32'd0,        32'h00000005, 1,  "rem_by0");
    addv(3'b101, 32'd5,          32'd0,        32'hFFFFFFFF, 1,  "divu_by0");
    addv(3'b111, 32'd5,          32'd0,        32'h00000005, 1,  "remu_by0");
    addv(3'b100, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf");
    addv(3'b110, 32'h80000000,   32'hFFFFFFFF, 32'h00000000, 1,  "rem_ovf");

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset ready", 32'(ready_o), 32'd1);
    chk("reset valid", 32'(valid_o), 32'd0);
    chk("reset res", res_o, 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].funct, vecs[i].op1, vecs[i].op2, vecs[i].exp, vecs[i].lat, vecs[i].name);

    // Flush in IDLE must block a same-cycle accept
    valid_i = 1'b1; flush_i = 1'b1; funct_i = 3'b101; op1_i = 32'd9; op2_i = 32'd0;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("idle_flush ready", 32'(ready_o), 32'd1);
    chk("idle_flush valid", 32'(valid_o), 32'd0);

    // Backpressure: result held, new requests ignored
    funct_i = 3'b000; op1_i = 32'd7; op2_i = 32'd3; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    seen = 0;
    while (!valid_o && seen < 100) begin @(posedge clk_i); #1; seen++; end
    chk("bp valid_rise", 32'(valid_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'b1; funct_i = 3'b101; op1_i = 32'd9; op2_i = 32'd3;
      @(posedge clk_i); #1;
      chk("bp valid_hold", 32'(valid_o), 32'd1);
      chk("bp res_hold", res_o, 32'd21);
      chk("bp ready_low", 32'(ready_o), 32'd0);
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("bp release ready", 32'(ready_o), 32'd1);
    chk("bp release valid", 32'(valid_o), 32'd0);
    chk("bp release res_kept", res_o, 32'd21);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      if (valid_o || !ready_o) seen++;
    end
    chk("bp nothing_queued", 32'(seen), 32'd0);

    // Flush on BUSY cycle 10
    funct_i = 3'b101; op1_i = 32'hFFFFFFFF; op2_i = 32'd3; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    chk("flush busy_before", 32'(ready_o), 32'd0);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush ready", 32'(ready_o), 32'd1);
    chk("flush valid", 32'(valid_o), 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    chk("flush no_result", 32'(seen), 32'd0);

    // Reset on BUSY cycle 10
    funct_i = 3'b101; op1_i = 32'hFFFFFFFF; op2_i = 32'd3; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midreset ready", 32'(ready_o), 32'd1);
    chk("midreset valid", 32'(valid_o), 32'd0);
    chk("midreset res", res_o, 32'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    chk("midreset no_result", 32'(seen), 32'd0);

    run_op(3'b101, 32'd100, 32'd7, 32'h0000000E, 33, "divu_100_7_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit, parametrised in operand width. Sits beside the single-cycle add/sub arithmetic unit in the execute stage. Takes multi-cycle M-extension ops behind a valid/ready handshake on both the operand and result sides. Uses one shift-add / restoring-divide datapath that retires one bit per cycle, plus a fast path for divide special cases.

Parameters:
XLEN, 32, operand and result width in bits (must be >= 4, even)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous, active-high reset
flush_i  input  1  synchronous abort of the in-flight operation (pipeline flush)
valid_i  input  1  operands/funct valid
ready_o  output  1  unit can accept an operation
funct_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op1_i  input  XLEN  rs1 value (multiplicand / dividend)
op2_i  input  XLEN  rs2 value (multiplier / divisor)
valid_o  output  1  res_o holds a completed result
ready_i  input  1  consumer accepts result
res_o  output  XLEN  result

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, ready_o=1, valid_o=0, res_o=0, all internal registers 0. Reset has priority over flush_i and all handshakes. It applies in any state, including mid-operation.
- States: IDLE, BUSY, DONE. ready_o=1 only in IDLE. valid_o=1 only in DONE.
- IDLE: an operation is accepted when valid_i && ready_o at an edge. At that edge the unit latches funct_i and the operand magnitudes with their sign flags. Later changes on the inputs are ignored.
- Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU treats op1 as signed and op2 as unsigned. MULHU/DIVU/REMU treat both as unsigned. The datapath works on unsigned magnitudes; the sign is applied at finalize.
- Multiply: forms the 2*XLEN-bit product. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits of the correctly signed product.
- Divide: quotient truncates toward zero. The remainder takes the sign of the dividend. Quotient sign = sign(op1) XOR sign(op2) for signed ops.
- Special cases (fast path, no iteration):
  - Divisor 0: DIV/DIVU returns all ones; REM/REMU returns op1.
  - Signed overflow (op1 = 1 followed by XLEN-1 zeros, op2 = all ones, DIV/REM): DIV returns op1; REM returns 0.
  - On accept, the unit goes IDLE->DONE with res_o set, so valid_o is high 1 cycle after the accept edge.
- Normal path: IDLE->BUSY on accept. BUSY runs for exactly XLEN cycles, one bit per cycle, driven by an iteration counter of width clog2(XLEN)+1. On the last BUSY cycle the sign is applied, res_o is registered, and the state goes to DONE. valid_o first goes high XLEN+1 cycles after the accept edge (33 for XLEN=32).
- DONE: res_o and valid_o stay stable until valid_o && ready_i at an edge. Then the state goes to IDLE and valid_o=0. res_o keeps its last value. There is no same-cycle re-accept, so back-to-back ops have a 1-cycle gap.
- flush_i=1 at an edge, in BUSY or DONE: state goes to IDLE, valid_o=0, and no result is emitted. In IDLE, flush_i also blocks an accept in the same cycle.
- While the unit is not in IDLE, valid_i is ignored and nothing is queued.

Test Plan:
- XLEN=32, MUL op1=7, op2=0xFFFFFFFD (-3) -> res_o=0xFFFFFFEB; valid_o rises exactly 33 cycles after accept; ready_o low cycles 1..34.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
- DIV 0xFFFFFFF9 (-7)/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC. REMU same operands -> 0x00000001.
- Special cases, each with valid_o 1 cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 0x00000005; DIVU 5/0 -> 0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0x00000000.
- Backpressure: hold ready_i=0 for 5 cycles after valid_o rises and pulse valid_i with new operands -> res_o/valid_o stable, ready_o=0, the new op is not accepted. Set ready_i=1 -> IDLE next cycle, and ready_o=1.
- Abort: assert flush_i on BUSY cycle 10 -> next cycle IDLE, ready_o=1, valid_o never asserted for that op. Repeat with rst_i -> same, res_o=0. Then DIVU 100/7 completes with res_o=0x0000000E.
